// File: rtl/pw_entry_fsm.sv
// Four-symbol push-button code entry FSM with entry timeout.
// Optional lockout after three consecutive failures: define PW_LOCKOUT_EN.
module pw_entry_fsm #(
  parameter logic [7:0] PASSWORD       = 8'b00_01_10_11,
  parameter int         TIMEOUT_CYCLES = 100_000_000,
  parameter int         LOCK_CYCLES    = 500_000_000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pa,
  input  logic       pb,
  input  logic       pc,
  input  logic       pd,
  output logic       dec_enable,
  output logic       fail,
  output logic [3:0] led,
  output logic       locked
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PW_LOCKOUT_EN
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ENTRY, CHECK} state_t;
`endif

  state_t            state;
  logic [2:0]        cnt;
  logic [TW-1:0]     tmr;
  logic [3:0][1:0]   slots;   // slots[3] holds the first symbol entered
  logic [3:0]        btn, prev, rise;
  logic              primed;
  logic              sym_vld;
  logic [1:0]        sym;

  assign btn = {pd, pc, pb, pa};

  // primed stays low for the first sampled cycle after reset so a button held
  // through reset release is captured as a level, never as a press
  assign rise    = btn & ~prev & {4{primed}};
  assign sym_vld = $onehot(rise);
  assign sym     = {rise[3] | rise[2], rise[3] | rise[1]};

`ifdef PW_LOCKOUT_EN
  logic [1:0]    fcnt;
  logic [LW-1:0] ltmr;
`endif

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tmr        <= '0;
      slots      <= '0;
      prev       <= '0;
      primed     <= 1'b0;
      dec_enable <= 1'b0;
      fail       <= 1'b0;
`ifdef PW_LOCKOUT_EN
      fcnt       <= '0;
      ltmr       <= '0;
      locked     <= 1'b0;
`endif
    end else begin
      prev       <= btn;
      primed     <= 1'b1;
      dec_enable <= 1'b0;
      fail       <= 1'b0;
      case (state)
        IDLE: begin
          if (sym_vld) begin
            slots[3] <= sym;
            cnt      <= 3'd1;
            tmr      <= '0;
            state    <= ENTRY;
          end
        end
        ENTRY: begin
          if (sym_vld) begin
            slots[2'd3 - cnt[1:0]] <= sym;
            cnt <= cnt + 3'd1;
            tmr <= '0;
            if (cnt == 3'd3) state <= CHECK;
          end else if (tmr >= TMO_LAST) begin
            // abandoned partial entry is dropped without a fail pulse
            cnt   <= '0;
            tmr   <= '0;
            state <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        CHECK: begin
          cnt   <= '0;
          state <= IDLE;
          if (slots == PASSWORD) begin
            dec_enable <= 1'b1;
`ifdef PW_LOCKOUT_EN
            fcnt       <= '0;
`endif
          end else begin
            fail <= 1'b1;
`ifdef PW_LOCKOUT_EN
            fcnt <= fcnt + 2'd1;
            if (fcnt == 2'd2) begin
              state  <= LOCK;
              locked <= 1'b1;
              ltmr   <= '0;
            end
`endif
          end
        end
`ifdef PW_LOCKOUT_EN
        LOCK: begin
          if (ltmr >= LOCK_LAST) begin
            state  <= IDLE;
            locked <= 1'b0;
            fcnt   <= '0;
            ltmr   <= '0;
          end else begin
            ltmr <= ltmr + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef PW_LOCKOUT_EN
  // LOCK_CYCLES has no consumer in this build; keep it referenced
  logic unused_lock;
  assign unused_lock = ^LOCK_CYCLES;
  assign locked      = 1'b0;
`endif

  always_comb begin
    led = 4'b0000;
    if (state == ENTRY || state == CHECK) begin
      case (cnt)
        3'd0:    led = 4'b0000;
        3'd1:    led = 4'b0001;
        3'd2:    led = 4'b0011;
        3'd3:    led = 4'b0111;
        default: led = 4'b1111;
      endcase
    end
  end

endmodule
